// File: rtl/time_set_pkg.sv
// Package for the time-set controller: state codes sent to the clock,
// field limits for BCD editing, and the edit-field codes used to drive
// display blinking.
package time_set_pkg;

    // State codes on the clock's state input
    typedef enum logic [3:0] {
        ST_RUN    = 4'd0,
        ST_SET_HH = 4'd1,
        ST_SET_MM = 4'd2,
        ST_SET_SS = 4'd3,
        ST_LOAD   = 4'd4
    } stateT;

    // Field being edited; EF_NONE outside the SET states
    typedef enum logic [1:0] {
        EF_NONE = 2'd0,
        EF_HH   = 2'd1,
        EF_MM   = 2'd2,
        EF_SS   = 2'd3
    } editFieldT;

    // Inclusive upper limits of each two-digit BCD field
    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    // Map a controller state onto the field it edits
    function automatic editFieldT fieldOf(input stateT s);
        editFieldT f;
        f = EF_NONE;
        case (s)
            ST_SET_HH: f = EF_HH;
            ST_SET_MM: f = EF_MM;
            ST_SET_SS: f = EF_SS;
            default:   f = EF_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/bcd_field_adj.sv
// Combinational one-step adjuster for a two-digit BCD field.
// Wraps at 00 and maxVal without touching any neighbouring field; a value
// that is not a legal BCD number within 00..maxVal becomes 00 on any step.
// With inc and dec both high (or both low) the value passes through.
module bcd_field_adj (
    input  logic [7:0] value,
    input  logic [7:0] maxVal,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] result
);

    logic [3:0] tens;
    logic [3:0] ones;
    logic       inRange;

    assign tens = value[7:4];
    assign ones = value[3:0];

    // Both digits must be decimal; with legal BCD digits a plain binary
    // compare against maxVal orders the same as the decimal values.
    assign inRange = (tens <= 4'd9) && (ones <= 4'd9) && (value <= maxVal);

    // Single inc or dec step with digit carry/borrow and field wrap
    always_comb begin
        result = value;
        if (inc ^ dec) begin
            if (!inRange) begin
                result = 8'h00;
            end else if (inc) begin
                if (value == maxVal) begin
                    result = 8'h00;
                end else if (ones == 4'd9) begin
                    result = {tens + 4'd1, 4'd0};
                end else begin
                    result = {tens, ones + 4'd1};
                end
            end else begin
                if (value == 8'h00) begin
                    result = maxVal;
                end else if (ones == 4'd0) begin
                    result = {tens - 4'd1, 4'd9};
                end else begin
                    result = {tens, ones - 4'd1};
                end
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller sitting in front of the running clock.
// Button pulses walk RUN -> SET_HH -> SET_MM -> SET_SS -> LOAD -> RUN;
// the live time is captured on entry, each field is edited in BCD, and
// LOAD is held one cycle so the clock latches time_set. An idle SET state
// times out back to RUN, discarding the edit.
// Optional feature macro: AUTO_REPEAT_EN (holding inc auto-repeats steps).
// Button inputs are single-cycle pulses, sampled every clock; there is no
// handshake, a pulse is either consumed or ignored on the cycle it arrives.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC      = 1_500_000_000,
    parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode_p,
    input  logic        inc_p,
    input  logic        dec_p,
    input  logic        inc_lvl,
    input  logic [23:0] time_cur,
    output logic [3:0]  state,
    output logic [23:0] time_set,
    output logic [1:0]  edit_field
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    stateT             stateQ;
    stateT             stateD;
    editFieldT         editFieldQ;
    editFieldT         editFieldD;
    logic [23:0]       timeSetQ;
    logic [IDLE_W-1:0] idleCnt;

    logic       inSet;
    logic       repStep;
    logic       incEvt;
    logic       anyPulse;
    logic       timeout;
    logic       adjInc;
    logic       adjDec;
    logic [7:0] fieldCur;
    logic [7:0] fieldMax;
    logic [7:0] fieldNew;

    assign inSet = (stateQ == ST_SET_HH) || (stateQ == ST_SET_MM) ||
                   (stateQ == ST_SET_SS);

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_MAX =
        (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned REP_W = $clog2(REP_MAX) + 1;
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_CYC - 1);

    logic [REP_W-1:0] repCnt;
    logic             repArmed;

    // First step after the hold delay, then one per rate period
    assign repStep = inSet && inc_lvl &&
                     (repArmed ? (repCnt == RATE_LAST) : (repCnt == DELAY_LAST));

    // Repeat timer: runs only while inc is held inside a SET state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repCnt   <= '0;
            repArmed <= 1'b0;
        end else if (!inSet || !inc_lvl) begin
            repCnt   <= '0;
            repArmed <= 1'b0;
        end else if (repStep) begin
            repCnt   <= '0;
            repArmed <= 1'b1;
        end else begin
            repCnt   <= repCnt + 1'b1;
        end
    end
`else
    logic unusedIncLvl;

    assign unusedIncLvl = inc_lvl;
    assign repStep      = 1'b0;
`endif

    assign incEvt   = inc_p | repStep;
    assign anyPulse = mode_p | inc_p | dec_p | repStep;
    assign timeout  = inSet && !anyPulse && (idleCnt == IDLE_LAST);

    // mode wins over adjustment; inc with dec cancels out
    assign adjInc = inSet && !mode_p && incEvt && !dec_p;
    assign adjDec = inSet && !mode_p && dec_p && !incEvt;

    // Select the field being edited and its limit for the shared adjuster
    always_comb begin
        fieldCur = timeSetQ[7:0];
        fieldMax = MS_MAX;
        case (stateQ)
            ST_SET_HH: begin
                fieldCur = timeSetQ[23:16];
                fieldMax = HH_MAX;
            end
            ST_SET_MM: fieldCur = timeSetQ[15:8];
            default:   fieldCur = timeSetQ[7:0];
        endcase
    end

    bcd_field_adj u_adj (
        .value  (fieldCur),
        .maxVal (fieldMax),
        .inc    (adjInc),
        .dec    (adjDec),
        .result (fieldNew)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= ST_RUN;
        end else begin
            stateQ <= stateD;
        end
    end

    // FSM next-state logic
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            ST_RUN: begin
                if (mode_p) stateD = ST_SET_HH;
            end
            ST_SET_HH: begin
                if (mode_p)       stateD = ST_SET_MM;
                else if (timeout) stateD = ST_RUN;
            end
            ST_SET_MM: begin
                if (mode_p)       stateD = ST_SET_SS;
                else if (timeout) stateD = ST_RUN;
            end
            ST_SET_SS: begin
                if (mode_p)       stateD = ST_LOAD;
                else if (timeout) stateD = ST_RUN;
            end
            ST_LOAD: stateD = ST_RUN;
            default: stateD = ST_RUN;
        endcase
    end

    // FSM output logic: edit field follows the state being entered
    always_comb begin
        editFieldD = EF_NONE;
        editFieldD = fieldOf(stateD);
    end

    // Registered edit-field output, updated together with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            editFieldQ <= EF_NONE;
        end else begin
            editFieldQ <= editFieldD;
        end
    end

    // Idle timer: counts quiet cycles in a SET state, any pulse restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idleCnt <= '0;
        end else if (!inSet || anyPulse) begin
            idleCnt <= '0;
        end else if (!timeout) begin
            idleCnt <= idleCnt + 1'b1;
        end
    end

    // Preset register: capture live time on entry, then per-field edits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeSetQ <= 24'h000000;
        end else if ((stateQ == ST_RUN) && mode_p) begin
            timeSetQ <= time_cur;
        end else if (adjInc || adjDec) begin
            case (stateQ)
                ST_SET_HH: timeSetQ[23:16] <= fieldNew;
                ST_SET_MM: timeSetQ[15:8]  <= fieldNew;
                default:   timeSetQ[7:0]   <= fieldNew;
            endcase
        end
    end

    assign state      = stateQ;
    assign edit_field = editFieldQ;
    assign time_set   = timeSetQ;

endmodule
